muldiv_ctrl: RTL and testbench

- Sequencer between the CPU control unit and the iterative multiply/divide units.
- Accepts one MULT/DIV request, latches the operands, and launches the selected unit with a one-cycle start pulse.
- Waits for the unit's done, then commits the result into the architectural hi/lo registers.
- Short-circuits divide-by-zero, guards against a hung unit with a watchdog, and provides busy for pipeline stall.

---
 rtl/muldiv_ctrl.sv | 125 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Sequencer between the CPU control unit and the iterative multiply/divide units.
// Latches operands, pulses the selected unit, and commits its result into hi/lo.
module muldiv_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic             timeout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             mult_start,
  output logic             div_start,
  output logic             unit_abort,
  input  logic             unit_done,
  input  logic [WIDTH-1:0] unit_hi,
  input  logic [WIDTH-1:0] unit_lo
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             done_d, div0_d, timeout_d, abort_d;
  logic             mult_start_d, div_start_d;
  logic             latch_en, commit_en;
  logic             dog_fire;

  assign dog_fire = (cnt == CNT_W'(TIMEOUT - 1));
  assign busy     = (state != S_IDLE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state;
    cnt_d        = cnt;
    done_d       = 1'b0;
    div0_d       = 1'b0;
    timeout_d    = 1'b0;
    abort_d      = 1'b0;
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    latch_en     = 1'b0;
    commit_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          if (op_div && (b == '0)) begin
            // divide-by-zero completes without ever waking a unit
            done_d = 1'b1;
            div0_d = 1'b1;
          end else begin
            state_d      = S_LAUNCH;
            mult_start_d = ~op_div;
            div_start_d  = op_div;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        if (unit_done) begin
          commit_en = 1'b1;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else if (dog_fire) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
          abort_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      done       <= 1'b0;
      div0       <= 1'b0;
      timeout    <= 1'b0;
      unit_abort <= 1'b0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      unit_a     <= '0;
      unit_b     <= '0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      done       <= done_d;
      div0       <= div0_d;
      timeout    <= timeout_d;
      unit_abort <= abort_d;
      mult_start <= mult_start_d;
      div_start  <= div_start_d;
      if (latch_en) begin
        unit_a <= a;
        unit_b <= b;
      end
      if (commit_en) begin
        hi <= unit_hi;
        lo <= unit_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed requests push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op_div = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div0, timeout, mult_start, div_start, unit_abort;
  logic [31:0] hi, lo, unit_a, unit_b;
  logic        unit_done;
  logic [31:0] unit_hi, unit_lo;

  muldiv_ctrl #(.WIDTH(32), .TIMEOUT(40), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op_div(op_div), .a(a), .b(b),
    .busy(busy), .done(done), .div0(div0), .timeout(timeout), .hi(hi), .lo(lo),
    .unit_a(unit_a), .unit_b(unit_b), .mult_start(mult_start), .div_start(div_start),
    .unit_abort(unit_abort), .unit_done(unit_done), .unit_hi(unit_hi), .unit_lo(unit_lo)
  );

  always #5 clock = ~clock;

  // Stub unit: asserts unit_done stub_lat cycles after a start pulse (0 = never).
  int          stub_lat = 0;
  int          stub_cnt = 0;
  logic [31:0] stub_hi = '0, stub_lo = '0;

  always @(posedge clock or posedge reset) begin
    if (reset)                                           stub_cnt <= 0;
    else if (mult_start || div_start)                    stub_cnt <= 1;
    else if (unit_abort || (stub_cnt != 0 && stub_cnt == stub_lat)) stub_cnt <= 0;
    else if (stub_cnt != 0)                              stub_cnt <= stub_cnt + 1;
  end

  assign unit_done = (stub_lat != 0) && (stub_cnt == stub_lat);
  assign unit_hi   = unit_done ? stub_hi : 32'hDEAD_BEEF;
  assign unit_lo   = unit_done ? stub_lo : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    logic        timeout;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_res(input logic [31:0] h, input logic [31:0] l,
                            input logic d0, input logic to);
    exp_t e;
    e.hi = h; e.lo = l; e.div0 = d0; e.timeout = to;
    sb.push_back(e);
  endtask

  // Monitor
  logic prev_done = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_one_cycle", {63'd0, prev_done}, 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", {63'd0, done}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_hi", {32'd0, hi}, {32'd0, e.hi});
          check("res_lo", {32'd0, lo}, {32'd0, e.lo});
          check("res_div0", {63'd0, div0}, {63'd0, e.div0});
          check("res_timeout", {63'd0, timeout}, {63'd0, e.timeout});
          check("res_abort", {63'd0, unit_abort}, {63'd0, e.timeout});
        end
      end else if (div0 || timeout || unit_abort) begin
        check("stray_pulse", {61'd0, div0, timeout, unit_abort}, 64'd0);
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic div, input logic [31:0] ia, input logic [31:0] ib);
    @(negedge clock);
    start = 1'b1; op_div = div; a = ia; b = ib;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Counts busy cycles and start pulses from the current negedge until busy drops.
  task automatic measure(output int bc, output int mc, output int dc);
    int guard = 0;
    bc = 0; mc = 0; dc = 0;
    while (busy && guard < 300) begin
      bc++; mc += int'(mult_start); dc += int'(div_start); guard++;
      @(negedge clock);
    end
    if (guard >= 300) check("busy_stuck", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    int bc, mc, dc;
    repeat (2) @(negedge clock);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_units", {unit_a, unit_b}, 64'd0);
    check("rst_starts", {62'd0, mult_start, div_start}, 64'd0);
    reset = 1'b0;

    // MULT 7 * -3 = -21
    stub_lat = 32; stub_hi = 32'hFFFF_FFFF; stub_lo = 32'hFFFF_FFEB;
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    issue(1'b0, 32'd7, 32'hFFFF_FFFD);
    check("mul_start_pulse", {63'd0, mult_start}, 64'd1);
    check("mul_no_div_start", {63'd0, div_start}, 64'd0);
    check("mul_unit_ab", {unit_a, unit_b}, {32'd7, 32'hFFFF_FFFD});
    measure(bc, mc, dc);
    check("mul_busy_cycles", 64'(bc), 64'd33);
    check("mul_start_count", 64'(mc), 64'd1);
    check("mul_div_count", 64'(dc), 64'd0);
    check("mul_done", {63'd0, done}, 64'd1);

    // DIV 100 / 7
    stub_lat = 10; stub_hi = 32'd2; stub_lo = 32'd14;
    expect_res(32'd2, 32'd14, 1'b0, 1'b0);
    issue(1'b1, 32'd100, 32'd7);
    check("div_start_pulse", {63'd0, div_start}, 64'd1);
    measure(bc, mc, dc);
    check("div_busy_cycles", 64'(bc), 64'd11);
    check("div_start_count", 64'(dc), 64'd1);
    check("div_mul_count", 64'(mc), 64'd0);

    // DIV 5 / 0 short-circuit
    expect_res(32'd2, 32'd14, 1'b1, 1'b0);
    issue(1'b1, 32'd5, 32'd0);
    check("div0_done", {62'd0, done, div0}, 64'd3);
    check("div0_busy", {63'd0, busy}, 64'd0);
    check("div0_no_start", {62'd0, mult_start, div_start}, 64'd0);
    @(negedge clock);
    check("div0_busy_after", {63'd0, busy}, 64'd0);
    check("div0_hilo_kept", {hi, lo}, {32'd2, 32'd14});

    // Input churn while busy, then back-to-back start on the done cycle
    stub_lat = 5; stub_hi = 32'h11; stub_lo = 32'h22;
    expect_res(32'h11, 32'h22, 1'b0, 1'b0);
    issue(1'b0, 32'h1234, 32'h5678);
    bc = 0; mc = 0; dc = 0;
    for (int g = 0; g < 300 && busy; g++) begin
      bc++; mc += int'(mult_start); dc += int'(div_start);
      check("churn_unit_ab", {unit_a, unit_b}, {32'h1234, 32'h5678});
      start = 1'b1; op_div = ~op_div; a = $urandom; b = $urandom;
      @(negedge clock);
    end
    check("churn_busy_cycles", 64'(bc), 64'd6);
    check("churn_start_counts", {32'(mc), 32'(dc)}, {32'd1, 32'd0});
    check("churn_done", {63'd0, done}, 64'd1);
    stub_lat = 3; stub_hi = 32'd2; stub_lo = 32'd22;
    expect_res(32'd2, 32'd22, 1'b0, 1'b0);
    start = 1'b1; op_div = 1'b1; a = 32'd200; b = 32'd9;
    @(negedge clock);
    start = 1'b0;
    check("b2b_div_start", {62'd0, mult_start, div_start}, 64'd1);
    check("b2b_unit_ab", {unit_a, unit_b}, {32'd200, 32'd9});
    measure(bc, mc, dc);
    check("b2b_busy_cycles", 64'(bc), 64'd4);

    // Watchdog: unit never answers
    stub_lat = 0;
    expect_res(32'd2, 32'd22, 1'b0, 1'b1);
    issue(1'b0, 32'd3, 32'd4);
    measure(bc, mc, dc);
    check("to_busy_cycles", 64'(bc), 64'd41);
    check("to_pulses", {61'd0, done, timeout, unit_abort}, 64'd7);
    @(negedge clock);
    check("to_pulses_clear", {61'd0, done, timeout, unit_abort}, 64'd0);

    // unit_done on the watchdog edge wins
    stub_lat = 40; stub_hi = 32'hAAAA; stub_lo = 32'h5555;
    expect_res(32'hAAAA, 32'h5555, 1'b0, 1'b0);
    issue(1'b0, 32'd3, 32'd4);
    measure(bc, mc, dc);
    check("race_busy_cycles", 64'(bc), 64'd41);

    // Asynchronous reset in the middle of WAIT: no done afterwards
    stub_lat = 0;
    issue(1'b1, 32'd50, 32'd5);
    repeat (10) @(negedge clock);
    check("rw_busy_before", {63'd0, busy}, 64'd1);
    #3 reset = 1'b1;
    #1;
    check("rw_busy", {63'd0, busy}, 64'd0);
    check("rw_hilo", {hi, lo}, 64'd0);
    check("rw_units", {unit_a, unit_b}, 64'd0);
    check("rw_outs", {59'd0, done, div0, timeout, mult_start, div_start}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    check("rw_idle_after", {63'd0, busy}, 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
